// File: rtl/seg_scan_mux.sv
// Time-multiplexed hex display scanner: prescaler-paced digit rotation with a frame-synchronous shadow register.
// Optional leading-zero blanking is compiled in when SEG_LZ_BLANK_EN is defined.
module seg_scan_mux #(
  parameter int NUM_DIGITS = 4,
  parameter int CLK_DIV    = 50000
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic                    load_i,
  output logic [3:0]              code_led_o,
  output logic [NUM_DIGITS-1:0]   digit_sel_o,
  output logic                    frame_o
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0]             cnt_q, cnt_d;
  logic [IW-1:0]             idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*NUM_DIGITS-1:0]   active_q, active_d;
  logic                      pending_q, pending_d;
  logic                      wrap_q, wrap_d;
  logic [3:0]                code_q, code_d;
  logic [NUM_DIGITS-1:0]     sel_q, sel_d;
  logic                      frame_q, frame_d;
  logic                      tick;
  logic                      wrap;
`ifdef SEG_LZ_BLANK_EN
  logic                      zero_above;
  logic                      blank;
`endif

  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    tick      = en_i && (cnt_q == CW'(CLK_DIV - 1));
    wrap      = tick && (idx_q == IW'(NUM_DIGITS - 1));
    wrap_d    = wrap;

    if (en_i) begin
      cnt_d = tick ? '0 : CW'(cnt_q + 1'b1);
    end
    if (tick) begin
      idx_d = wrap ? '0 : IW'(idx_q + 1'b1);
    end

    // Apply consumes the old shadow; a coincident load then re-arms pending.
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (load_i) begin
      shadow_d  = value_i;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    code_d = 4'h0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) code_d = active_q[4*k +: 4];
    end
    sel_d   = en_i ? ~(NUM_DIGITS'(1) << idx_q) : '1;
    frame_d = wrap_q && en_i;
`ifdef SEG_LZ_BLANK_EN
    zero_above = 1'b1;
    blank      = 1'b0;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      zero_above = zero_above && (active_q[4*k +: 4] == 4'h0);
      if (idx_q == IW'(k) && zero_above) blank = 1'b1;
    end
    if (blank) sel_d = '1;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      wrap_q    <= 1'b0;
      code_q    <= 4'h0;
      sel_q     <= '1;
      frame_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      wrap_q    <= wrap_d;
      code_q    <= code_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end

  assign code_led_o  = code_q;
  assign digit_sel_o = sel_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized bench for seg_scan_mux (4 digits, 4 cycles per slot) against a slot-counting reference model.
module tb_seg_scan_mux;
  localparam int N   = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [4*N-1:0] value;
  logic          load;
  logic [3:0]    code;
  logic [N-1:0]  sel;
  logic          frame;

  int n_checks = 0;
  int n_errors = 0;

  seg_scan_mux #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .value_i(value), .load_i(load),
    .code_led_o(code), .digit_sel_o(sel), .frame_o(frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: position in the scan is derived from the count of enabled cycles.
  int            m_e;
  int            m_idx;
  bit            m_wrapped;
  bit            m_pend;
  logic [4*N-1:0] m_shadow, m_active;
  logic [3:0]    exp_code;
  logic [N-1:0]  exp_sel;
  logic          exp_frame;
  bit            chk_on = 0;
  int            frame_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; m_idx = 0; m_wrapped = 0; m_pend = 0;
      m_shadow = '0; m_active = '0;
      exp_code = 4'h0; exp_sel = '1; exp_frame = 1'b0;
    end else begin
      bit wrapped_now;
      exp_code  = 4'((m_active >> (4*m_idx)) & 16'hF);
      exp_sel   = en ? ~(N'(1) << m_idx) : '1;
`ifdef SEG_LZ_BLANK_EN
      if (m_idx > 0 && (m_active >> (4*m_idx)) == 0) exp_sel = '1;
`endif
      exp_frame = m_wrapped && en;
      wrapped_now = 0;
      if (en) begin
        m_e = m_e + 1;
        if (m_e % DIV == 0) begin
          m_idx = (m_e / DIV) % N;
          wrapped_now = (m_idx == 0);
        end
      end
      m_wrapped = wrapped_now;
      if (wrapped_now && m_pend) begin
        m_active = m_shadow;
        m_pend = 0;
      end
      if (load) begin
        m_shadow = value;
        m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("code", 32'(code), 32'(exp_code));
      check("sel", 32'(sel), 32'(exp_sel));
      check("frame", 32'(frame), 32'(exp_frame));
    end
    if (frame === 1'b1) frame_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [4*N-1:0] v);
    value = v; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  // Waits until the current cycle is the last cycle of the last slot (an enabled wrap tick).
  task automatic wait_wrap_tick();
    int i;
    for (i = 0; i < 200; i++) begin
      if (m_e % DIV == DIV - 1 && m_idx == N - 1 && en) break;
      cyc(1);
    end
    if (i == 200) check("wrap_timeout", 1, 0);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; value = '0; load = 1'b0;
    cyc(3);
    #1;
    check("rst_code", 32'(code), 0);
    check("rst_sel", 32'(sel), 32'hF);
    check("rst_frame", 32'(frame), 0);
    rst_n = 1'b1;
    chk_on = 1;

    // Scenario 1: steady scanning, one frame pulse per 16 cycles
    do_load(16'h1234);
    cyc(20);
    frame_cnt = 0;
    cyc(64);
    check("frames_per_64", 32'(frame_cnt), 4);

    // Scenario 2: last load before the wrap wins
    cyc(2);
    do_load(16'hAAAA);
    do_load(16'h5678);
    cyc(40);

    // Scenario 3: load coinciding with an applying wrap tick
    do_load(16'h1111);
    wait_wrap_tick();
    do_load(16'h9999);
    cyc(40);

    // Scenario 4: freeze mid-slot 2
    for (int i = 0; i < 100 && !(m_idx == 2 && m_e % DIV == 1); i++) cyc(1);
    en = 1'b0;
    cyc(10);
    check("frozen_sel", 32'(sel), 32'hF);
    en = 1'b1;
    cyc(20);

    // Scenario 5: asynchronous reset with a load pending
    do_load(16'h4321);
    cyc(2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_code", 32'(code), 0);
    check("async_sel", 32'(sel), 32'hF);
    check("async_frame", 32'(frame), 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(40);

    // Leading-zero patterns (plain display without blanking)
    do_load(16'h0050);
    cyc(40);
    do_load(16'h0000);
    cyc(40);
    do_load(16'h0F00);
    cyc(40);

    // Random mix of loads, enable drops and values
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 15) != 0);
      load  = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 3))
        0: value = 16'($urandom_range(0, 15));
        1: value = 16'($urandom_range(0, 255));
        default: value = 16'($urandom);
      endcase
      cyc(1);
    end
    load = 1'b0; en = 1'b1;
    cyc(40);

    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; no other clock or reset SHALL exist.
REQ-002 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 2..8.
REQ-003 Parameter CLK_DIV, default 50000: clk_i cycles per digit slot, legal range >= 2.
REQ-004 clk_i  input  1  system clock; all state on rising edge.
REQ-005 rst_n_i  input  1  asynchronous active-low reset.
REQ-006 en_i  input  1  scan enable; low freezes the scan and blanks the display.
REQ-007 value_i  input  4*NUM_DIGITS  hex value; nibble k drives digit k; digit 0 is the LSD.
REQ-008 load_i  input  1  single-cycle strobe capturing value_i into the shadow register.
REQ-009 code_led_o  output  4  nibble code for the active digit, feeding the downstream 7-segment decoder.
REQ-010 digit_sel_o  output  NUM_DIGITS  digit anode select, active-low, one-cold.
REQ-011 frame_o  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Function
REQ-012 The prescaler SHALL count 0..CLK_DIV-1 while en_i=1 and SHALL wrap to 0; a tick SHALL occur in the cycle it equals CLK_DIV-1.
REQ-013 On a tick, the digit index SHALL advance by 1 and wrap from NUM_DIGITS-1 to 0.
REQ-014 load_i=1 SHALL write value_i to the shadow register and set pending; repeated loads before apply SHALL overwrite it (last wins).
REQ-015 On a tick that wraps the index to 0 with pending=1, the active register SHALL take the shadow value and pending SHALL clear, so no frame shows mixed values.
REQ-016 If load_i coincides with an applying wrap tick, the previous shadow value SHALL be applied, the new value SHALL be stored, and pending SHALL remain 1.
REQ-017 code_led_o and digit_sel_o SHALL be registered, SHALL change in the same cycle, and SHALL reflect the index and active value with 1-cycle latency after the index update.
REQ-018 digit_sel_o SHALL drive bit index low and all other bits high; code_led_o SHALL equal active nibble index.
REQ-019 frame_o SHALL be asserted in the cycle after the wrap tick, aligned with digit 0 appearing on the outputs.
REQ-020 With en_i=0, the prescaler and index SHALL hold, digit_sel_o SHALL be all ones, frame_o SHALL be 0, and load_i SHALL still be accepted.
REQ-021 When en_i returns to 1, scanning SHALL resume from the held prescaler and index values, with outputs valid 1 cycle later.

Reset
REQ-022 Reset assertion SHALL asynchronously force: prescaler=0, index=0, shadow=0, active=0, pending=0, code_led_o=4'h0, digit_sel_o=all ones, frame_o=0.
REQ-023 Reset asserted mid-frame or mid-slot SHALL discard any pending load.
REQ-024 After reset release, the first tick SHALL occur CLK_DIV cycles later.

Configuration
REQ-025 Macro SEG_LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-026 With SEG_LZ_BLANK_EN defined, any digit k>0 whose active nibble and all higher nibbles are zero SHALL have digit_sel_o all ones during its slot; digit 0 SHALL never be blanked.
REQ-027 Without SEG_LZ_BLANK_EN, all digits SHALL be displayed, including zeros, and no blanking logic SHALL be synthesised.

Verification (NUM_DIGITS=4, CLK_DIV=4)
REQ-028 Scenario 1: load 0x1234, run 2 frames -> after the first wrap, slots show (code, sel) = (4, 1110), (3, 1101), (2, 1011), (1, 0111), each 4 cycles long, and frame_o pulses once per 16 cycles.
REQ-029 Scenario 2: load 0xAAAA, then 0x5678 within the same frame -> only 0x5678 is ever displayed after the wrap.
REQ-030 Scenario 3: load 0x9999 in the same cycle as an applying wrap tick, with shadow=0x1111 -> the frame shows 1111 and the next frame shows 9999.
REQ-031 Scenario 4: drop en_i for 10 cycles mid-slot 2 -> digit_sel_o=1111 and the prescaler is frozen; on resume, slot 2 completes its remaining cycles.
REQ-032 Scenario 5: assert rst_n_i=0 asynchronously mid-slot with a pending load -> outputs take reset values immediately, and 0x0000 is displayed after release.
REQ-033 Scenario 6 (SEG_LZ_BLANK_EN defined): value 0x0050 -> slots 3 and 2 give sel=1111, slot 1 shows 5, slot 0 shows 0; value 0x0000 -> only digit 0 is lit.
